// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Definitions shared by the iterative multiply/divide unit:
//   MD_WIDTH / ITER  operand width and iteration count (one bit per cycle)
//   md_op_e          MD_OP encodings (MULTU, MULT, DIVU, DIV)
//   md_state_e       sequencer states (IDLE, RUN, FIX)
//   md_op_is_div     op class helper (bit 1 selects divide)
//   md_op_is_signed  signedness helper (bit 0 selects signed)
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int MD_WIDTH = 32;
    localparam int ITER     = MD_WIDTH;

    typedef enum logic [1:0] {
        MD_MULTU = 2'b00,
        MD_MULT  = 2'b01,
        MD_DIVU  = 2'b10,
        MD_DIV   = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_FIX  = 2'b10
    } md_state_e;

    function automatic logic md_op_is_div(input logic [1:0] op);
        return (op == MD_DIVU) || (op == MD_DIV);
    endfunction

    function automatic logic md_op_is_signed(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/mult_div_step.sv
// ---------------------------------------------------------------------------
// mult_div_step
// One combinational iteration of the multiply/divide datapath.
//   is_div    1 = restoring-divide step, 0 = shift-add multiply step
//   acc_in    2*WIDTH accumulator {upper, lower}
//   operand   multiplicand magnitude or divisor magnitude
//   acc_out   accumulator after this iteration
// Multiply: lower half holds the not-yet-consumed multiplier bits; the upper
//   half collects partial sums and the pair shifts right each step.
// Divide: upper half is the partial remainder, lower half holds the dividend
//   bits still to be consumed, with quotient bits shifted in at the LSB.
// ---------------------------------------------------------------------------
module mult_div_step
    import mips_pkg::*;
#(
    parameter int WIDTH = ITER
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc_in,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_out
);

    logic [WIDTH:0]     mul_upper;
    logic [2*WIDTH:0]   shifted;
    logic [WIDTH-1:0]   diff;
    logic               fits;

    always_comb begin
        // Keep the carry out of the partial sum; it becomes the new MSB.
        mul_upper = {1'b0, acc_in[2*WIDTH-1:WIDTH]};
        if (acc_in[0]) begin
            mul_upper = mul_upper + {1'b0, operand};
        end

        // Shifted remainder needs WIDTH+1 bits; the subtraction result is
        // always below the divisor, so WIDTH bits are enough for it.
        shifted = {acc_in, 1'b0};
        fits    = shifted[2*WIDTH:WIDTH] >= {1'b0, operand};
        diff    = shifted[2*WIDTH-1:WIDTH] - operand;

        if (is_div) begin
            if (fits) begin
                acc_out = {diff, shifted[WIDTH-1:1], 1'b1};
            end else begin
                acc_out = {shifted[2*WIDTH-1:1], 1'b0};
            end
        end else begin
            acc_out = {mul_upper, acc_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
//   CLK, RESET        clock, asynchronous active-high reset
//   MD_START, MD_OP   one-cycle request and operation, sampled only in IDLE
//   MD_IN_1, MD_IN_2  multiplicand/dividend, multiplier/divisor
//   MD_HI_WE, MD_LO_WE, MD_WDATA   MTHI/MTLO writes, honoured only in IDLE
//   MD_BUSY           high while an operation is in flight (33 cycles)
//   MD_DONE           one-cycle pulse when new HI/LO are visible
//   MD_DIV_ZERO       sticky zero-divisor flag, cleared by the next start
//   MD_HI, MD_LO      HI/LO registers
// The datapath works on magnitudes; signs are latched at start and applied
// in the FIX cycle.
// ---------------------------------------------------------------------------
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = ITER
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               MD_START,
    input  logic [1:0]         MD_OP,
    input  logic [WIDTH-1:0]   MD_IN_1,
    input  logic [WIDTH-1:0]   MD_IN_2,
    input  logic               MD_HI_WE,
    input  logic               MD_LO_WE,
    input  logic [WIDTH-1:0]   MD_WDATA,
    output logic               MD_BUSY,
    output logic               MD_DONE,
    output logic               MD_DIV_ZERO,
    output logic [WIDTH-1:0]   MD_HI,
    output logic [WIDTH-1:0]   MD_LO
);

    localparam int CNT_W = $clog2(WIDTH);

    md_state_e            state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d, step_acc;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [WIDTH-1:0]     raw_a_q, raw_a_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                 is_div_q, is_div_d;
    logic                 res_neg_q, res_neg_d;
    logic                 rem_neg_q, rem_neg_d;
    logic                 zdiv_q, zdiv_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 div_zero_q, div_zero_d;

    logic                 in_signed;
    logic                 sign_a, sign_b;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix;

    mult_div_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div_q),
        .acc_in  (acc_q),
        .operand (opnd_q),
        .acc_out (step_acc)
    );

    always_comb begin
        in_signed = md_op_is_signed(MD_OP);
        sign_a    = in_signed & MD_IN_1[WIDTH-1];
        sign_b    = in_signed & MD_IN_2[WIDTH-1];
        // The most negative value maps onto itself, which is the correct
        // unsigned magnitude.
        mag_a     = sign_a ? -MD_IN_1 : MD_IN_1;
        mag_b     = sign_b ? -MD_IN_2 : MD_IN_2;

        prod_fix  = res_neg_q ? -acc_q : acc_q;
        quot_fix  = res_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix   = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        raw_a_d    = raw_a_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        is_div_d   = is_div_q;
        res_neg_d  = res_neg_q;
        rem_neg_d  = rem_neg_q;
        zdiv_d     = zdiv_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;

        case (state_q)
            MD_IDLE: begin
                if (MD_HI_WE) hi_d = MD_WDATA;
                if (MD_LO_WE) lo_d = MD_WDATA;
                if (MD_START) begin
                    state_d    = MD_RUN;
                    busy_d     = 1'b1;
                    count_d    = '0;
                    is_div_d   = md_op_is_div(MD_OP);
                    res_neg_d  = sign_a ^ sign_b;
                    rem_neg_d  = sign_a;
                    zdiv_d     = (MD_IN_2 == '0);
                    raw_a_d    = MD_IN_1;
                    acc_d      = {{WIDTH{1'b0}}, mag_a};
                    opnd_d     = mag_b;
                    div_zero_d = 1'b0;
                end
            end
            MD_RUN: begin
                acc_d = step_acc;
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    state_d = MD_FIX;
                    count_d = '0;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            MD_FIX: begin
                state_d = MD_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (is_div_q) begin
                    if (zdiv_q) begin
                        hi_d       = raw_a_q;
                        lo_d       = '1;
                        div_zero_d = 1'b1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: begin
                state_d = MD_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= MD_IDLE;
            count_q    <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            raw_a_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            is_div_q   <= 1'b0;
            res_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            zdiv_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            raw_a_q    <= raw_a_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            is_div_q   <= is_div_d;
            res_neg_q  <= res_neg_d;
            rem_neg_q  <= rem_neg_d;
            zdiv_q     <= zdiv_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign MD_BUSY     = busy_q;
    assign MD_DONE     = done_q;
    assign MD_DIV_ZERO = div_zero_q;
    assign MD_HI       = hi_q;
    assign MD_LO       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
// Directed vector table, hand-written corner sequences (busy-time request,
// MTHI, reset mid-operation) and random operations checked against a
// 64-bit arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

    logic        CLK;
    logic        RESET;
    logic        MD_START;
    logic [1:0]  MD_OP;
    logic [31:0] MD_IN_1, MD_IN_2;
    logic        MD_HI_WE, MD_LO_WE;
    logic [31:0] MD_WDATA;
    logic        MD_BUSY, MD_DONE, MD_DIV_ZERO;
    logic [31:0] MD_HI, MD_LO;

    int total = 0;
    int bad   = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .MD_START    (MD_START),
        .MD_OP       (MD_OP),
        .MD_IN_1     (MD_IN_1),
        .MD_IN_2     (MD_IN_2),
        .MD_HI_WE    (MD_HI_WE),
        .MD_LO_WE    (MD_LO_WE),
        .MD_WDATA    (MD_WDATA),
        .MD_BUSY     (MD_BUSY),
        .MD_DONE     (MD_DONE),
        .MD_DIV_ZERO (MD_DIV_ZERO),
        .MD_HI       (MD_HI),
        .MD_LO       (MD_LO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural meaning of each op.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        dz = 1'b0;
        hi = 32'd0;
        lo = 32'd0;
        case (op)
            2'b00: begin
                up = ua * ub;
                hi = up[63:32];
                lo = up[31:0];
            end
            2'b01: begin
                sp = sa * sb;
                hi = sp[63:32];
                lo = sp[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    dz = 1'b1;
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else if (op == 2'b10) begin
                    up = ua / ub;
                    lo = up[31:0];
                    up = ua % ub;
                    hi = up[31:0];
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    lo = sq[31:0];
                    hi = sr[31:0];
                end
            end
        endcase
    endfunction

    // Launch an op (START sampled at the next edge = edge 0), observe cycles
    // 1..34 and check timing and results. Returns in cycle 34, so a following
    // call issues a back-to-back start. inject>0 pulses START and MTLO in that
    // busy cycle; both must be ignored.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inject, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dz, input string tag);
        int          busy_n;
        int          early_done;
        logic [31:0] lo_before;
        lo_before = MD_LO;
        MD_OP     = op;
        MD_IN_1   = a;
        MD_IN_2   = b;
        MD_START  = 1'b1;
        @(posedge CLK); #1;
        MD_START  = 1'b0;
        busy_n     = 0;
        early_done = 0;
        for (int c = 1; c <= 34; c++) begin
            if (c == 1) chk({tag, "_dz_cleared"}, {31'd0, MD_DIV_ZERO}, 32'd0);
            if (inject > 0 && c == inject + 1) begin
                MD_START = 1'b0;
                MD_LO_WE = 1'b0;
                chk({tag, "_lo_busy_write"}, MD_LO, lo_before);
            end
            if (inject > 0 && c == inject) begin
                MD_START = 1'b1;
                MD_OP    = ~op;
                MD_IN_1  = 32'h0000_0055;
                MD_IN_2  = 32'h0000_0003;
                MD_LO_WE = 1'b1;
                MD_WDATA = 32'h0000_1234;
            end
            if (c <= 33) begin
                if (MD_BUSY) busy_n++;
                if (MD_DONE) early_done++;
            end
            if (c < 34) begin
                @(posedge CLK); #1;
            end
        end
        chk({tag, "_busy_cycles"}, busy_n, 33);
        chk({tag, "_early_done"}, early_done, 0);
        chk({tag, "_done"}, {31'd0, MD_DONE}, 32'd1);
        chk({tag, "_busy_end"}, {31'd0, MD_BUSY}, 32'd0);
        chk({tag, "_hi"}, MD_HI, exp_hi);
        chk({tag, "_lo"}, MD_LO, exp_lo);
        chk({tag, "_dz"}, {31'd0, MD_DIV_ZERO}, {31'd0, exp_dz});
        $display("op=%0d a=%h b=%h hi=%h lo=%h dz=%0d [%s]", op, a, b, MD_HI, MD_LO, MD_DIV_ZERO, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] mhi, mlo;
        logic        mdz;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int          sel;

        vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1]  = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[2]  = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[4]  = '{2'b10, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
        vecs[5]  = '{2'b00, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 32'h0000_000C, 1'b0};
        vecs[6]  = '{2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[7]  = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
        vecs[8]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFF, 32'h0000_0007, 32'h0000_0000, 1'b0};
        vecs[9]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[10] = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0};
        vecs[11] = '{2'b01, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0};

        RESET    = 1'b1;
        MD_START = 1'b0;
        MD_OP    = 2'b00;
        MD_IN_1  = 32'd0;
        MD_IN_2  = 32'd0;
        MD_HI_WE = 1'b0;
        MD_LO_WE = 1'b0;
        MD_WDATA = 32'd0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", {31'd0, MD_BUSY}, 32'd0);
        chk("rst_done", {31'd0, MD_DONE}, 32'd0);
        chk("rst_dz",   {31'd0, MD_DIV_ZERO}, 32'd0);
        chk("rst_hi",   MD_HI, 32'd0);
        chk("rst_lo",   MD_LO, 32'd0);
        RESET = 1'b0;
        @(posedge CLK); #1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, vecs[i].hi, vecs[i].lo, vecs[i].dz,
                   $sformatf("vec%0d", i));
        end

        // Request and MTLO while busy: both ignored.
        run_op(2'b00, 32'h1234_5678, 32'h0000_0010, 5, 32'h0000_0001, 32'h2345_6780, 1'b0, "busy_req");

        // DONE drops at the next edge when nothing new starts.
        @(posedge CLK); #1;
        chk("done_one_pulse", {31'd0, MD_DONE}, 32'd0);

        // MTHI in IDLE, visible the next cycle; LO untouched.
        MD_HI_WE = 1'b1;
        MD_WDATA = 32'h0000_ABCD;
        @(posedge CLK); #1;
        MD_HI_WE = 1'b0;
        chk("mthi_hi", MD_HI, 32'h0000_ABCD);
        chk("mthi_lo", MD_LO, 32'h2345_6780);
        $display("op=mthi data=0000abcd hi=%h lo=%h", MD_HI, MD_LO);

        // Reset in cycle 10 of a DIVU: everything clears at once.
        MD_OP    = 2'b10;
        MD_IN_1  = 32'd1000;
        MD_IN_2  = 32'd7;
        MD_START = 1'b1;
        @(posedge CLK); #1;
        MD_START = 1'b0;
        repeat (9) begin
            @(posedge CLK); #1;
        end
        chk("pre_abort_busy", {31'd0, MD_BUSY}, 32'd1);
        RESET = 1'b1;
        #1;
        chk("abort_busy", {31'd0, MD_BUSY}, 32'd0);
        chk("abort_done", {31'd0, MD_DONE}, 32'd0);
        chk("abort_hi",   MD_HI, 32'd0);
        chk("abort_lo",   MD_LO, 32'd0);
        $display("op=reset_abort busy=%0d hi=%h lo=%h", MD_BUSY, MD_HI, MD_LO);
        @(posedge CLK); #1;
        RESET = 1'b0;
        // Started immediately; an un-aborted DIVU would pulse DONE mid-run here.
        run_op(2'b00, 32'd6, 32'd7, 0, 32'd0, 32'd42, 1'b0, "post_reset");

        // Random operations against the reference model.
        for (int i = 0; i < 30; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = 32'd0;
            if (sel == 1) rb = 32'($urandom_range(1, 15));
            if (sel == 2) ra = 32'h8000_0000;
            if (sel == 3) rb = 32'hFFFF_FFFF;
            model(rop, ra, rb, mhi, mlo, mdz);
            run_op(rop, ra, rb, 0, mhi, mlo, mdz, $sformatf("rnd%0d", i));
        end

        @(posedge CLK); #1;
        chk("final_done_low", {31'd0, MD_DONE}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit that sits beside the ALU in the execute stage. It takes the same two 32-bit register operands and computes MULT/MULTU/DIV/DIV U results over 33 busy cycles into architectural HI/LO registers. It replaces the ALU's combinational `*` and `/` paths. It raises BUSY so the control path can stall instruction fetch until DONE.

## Interface
Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH each, product is 2·WIDTH.

Ports:
- CLK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-high reset.
- MD_START  in  1  one-cycle request; sampled only in IDLE.
- MD_OP  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with MD_START.
- MD_IN_1  in  WIDTH  multiplicand / dividend (rs).
- MD_IN_2  in  WIDTH  multiplier / divisor (rt).
- MD_HI_WE  in  1  MTHI write strobe.
- MD_LO_WE  in  1  MTLO write strobe.
- MD_WDATA  in  WIDTH  data for MTHI/MTLO.
- MD_BUSY  out  1  high while an operation is in flight.
- MD_DONE  out  1  one-cycle pulse when new HI/LO are visible.
- MD_DIV_ZERO  out  1  sticky flag: last divide had a zero divisor; cleared by the next MD_START.
- MD_HI  out  WIDTH  HI register (product upper half / remainder).
- MD_LO  out  WIDTH  LO register (product lower half / quotient).

## Operation
- States:
  - IDLE: on MD_START, go to RUN. Latch the op, latch |MD_IN_1| and |MD_IN_2| (two's-complement magnitude when the op is signed, raw value otherwise), latch the result-sign bits, set count=0.
  - RUN: one iteration per cycle. At count=WIDTH-1, go to FIX.
  - FIX: apply sign correction, write HI/LO, go to IDLE.
- Multiply: radix-2 shift-add on a 2·WIDTH unsigned accumulator. For signed ops, negate the full 2·WIDTH product if the operand signs differ.
- Divide: restoring division, one quotient bit per iteration.
  - Signed quotient truncates toward zero; it is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (DIV): LO=0x80000000, HI=0. No trap.
- Divisor zero (DIV or DIVU):
  - Same latency as a normal divide.
  - LO=all-ones, HI=MD_IN_1 as latched (unmodified).
  - MD_DIV_ZERO=1 at DONE.
- MD_START while BUSY: ignored; no queueing.
- MD_HI_WE/MD_LO_WE:
  - Honoured only in IDLE; ignored while BUSY.
  - If asserted together with MD_START, the write lands, and the FIX write overwrites it later.
- Reset values: MD_HI=0, MD_LO=0, MD_BUSY=0, MD_DONE=0, MD_DIV_ZERO=0, state IDLE, count 0.
- RESET mid-operation: aborts immediately. No DONE pulse, HI/LO=0. A new MD_START is accepted on the first edge after RESET deasserts.

## Timing
- MD_START is sampled at edge 0.
- MD_BUSY=1 during cycles 1..33: 32 RUN cycles, then 1 FIX cycle.
- HI/LO update at edge 33. MD_DONE=1 and MD_BUSY=0 in cycle 34.
- Back-to-back: MD_START may be asserted in cycle 34. MD_DONE deasserts at edge 34 regardless.
- MTHI/MTLO writes are visible the cycle after the strobe edge.
- All outputs are registered; there is no combinational path from inputs to outputs.
- count is $clog2(WIDTH) bits wide and does not wrap inside one operation.

## Structure
- Shared package `mips_pkg` holds:
  - MD_OP encodings (MD_MULTU, MD_MULT, MD_DIVU, MD_DIV).
  - State enum (MD_IDLE, MD_RUN, MD_FIX).
  - The ITER constant (=WIDTH).
- One combinational sub-module, `mult_div_step`:
  - Inputs: op class (mul/div), accumulator, operand.
  - Output: next accumulator for a single iteration.
  - The top level keeps the FSM, counter, sign latches and HI/LO.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 34 cycles HI=0xFFFFFFFE, LO=0x00000001, DONE pulses once, BUSY high for exactly 33 cycles.
- MULT 0xFFFFFFFD (−3) × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV 0xFFFFFFF9 (−7) ÷ 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIV 0x80000000 ÷ 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 100 ÷ 0 -> DIV_ZERO=1, LO=0xFFFFFFFF, HI=0x00000064. Next MULTU 3×4 -> DIV_ZERO=0, LO=12, HI=0.
- MD_START and MD_LO_WE (0x1234) pulsed at cycle 5 of a busy op -> both ignored, and the result matches the original op. MTHI 0xABCD in IDLE -> HI=0xABCD next cycle.
- RESET asserted at cycle 10 of a DIVU -> BUSY, DONE, HI, LO all 0 immediately, and no DONE afterwards. MULTU 6×7 started right after reset release -> LO=42 at cycle 34.
